// File: rtl/pes_req_stager_pkg.sv
// Shared defaults and types for the request stager in front of the round-robin arbiter.
// Every file in the stager imports this package.
package pes_req_stager_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int DEPTH_DEF     = 4;
  localparam int CNT_W_DEF     = 4;
  localparam int MAX_COUNT_DEF = 100;
  localparam int WAIT_W        = 16;

  // What the pending counter does this cycle.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_INC  = 2'd1,
    OP_DEC  = 2'd2
  } chan_op_e;

endpackage

// File: rtl/pes_req_chan.sv
// One requestor channel: a saturating pending counter, a starvation wait timer,
// and sticky overflow and spurious-grant flags.
module pes_req_chan
  import pes_req_stager_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int MAX_COUNT = MAX_COUNT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic grant,
  output logic req,
  output logic full,
  output logic ovf,
  output logic spur,
  output logic starve
);

  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [WAIT_W-1:0] MAX_C   = WAIT_W'(MAX_COUNT);

  logic [CNT_W-1:0]  pend_cnt_q, pend_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              ovf_q, ovf_d;
  logic              spur_q, spur_d;
  logic              empty, is_full, pop;
  chan_op_e          op;

  always_comb begin
    empty   = (pend_cnt_q == '0);
    is_full = (pend_cnt_q == DEPTH_C);
    // A grant only retires something when there is something to retire.
    pop     = grant & ~empty;

    op = OP_HOLD;
    if (push && !pop && !is_full) begin
      op = OP_INC;
    end else if (pop && !push) begin
      op = OP_DEC;
    end

    pend_cnt_d = pend_cnt_q;
    case (op)
      OP_INC:  pend_cnt_d = pend_cnt_q + CNT_W'(1);
      OP_DEC:  pend_cnt_d = pend_cnt_q - CNT_W'(1);
      default: pend_cnt_d = pend_cnt_q;
    endcase

    ovf_d  = ovf_q | (push & ~pop & is_full);
    spur_d = spur_q | (grant & empty);

    // Saturating, so starve stays asserted until the channel is served.
    wait_cnt_d = wait_cnt_q;
    if (pop || empty) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < MAX_C) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cnt_q <= '0;
      wait_cnt_q <= '0;
      ovf_q      <= 1'b0;
      spur_q     <= 1'b0;
    end else begin
      pend_cnt_q <= pend_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      ovf_q      <= ovf_d;
      spur_q     <= spur_d;
    end
  end

  assign req    = (pend_cnt_q != '0);
  assign full   = (pend_cnt_q == DEPTH_C);
  assign ovf    = ovf_q;
  assign spur   = spur_q;
  assign starve = (wait_cnt_q >= MAX_C);

endmodule

// File: rtl/pes_req_stager.sv
// Request stager: NUM_REQ independent channels turning push pulses into
// level requests for the arbiter, with debug flags per channel.
module pes_req_stager
  import pes_req_stager_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int MAX_COUNT = MAX_COUNT_DEF
) (
`ifdef USE_POWER_PINS
  inout  wire                vccd1,
  inout  wire                vssd1,
`endif
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] push,
  input  logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] full,
  output logic [NUM_REQ-1:0] ovf,
  output logic [NUM_REQ-1:0] spur,
  output logic [NUM_REQ-1:0] starve,
  output logic [NUM_REQ-1:0] io_oeb
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : gen_chan
      pes_req_chan #(
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W),
        .MAX_COUNT (MAX_COUNT)
      ) u_chan (
        .clk    (clk),
        .rst    (rst),
        .push   (push[gi]),
        .grant  (grant[gi]),
        .req    (req[gi]),
        .full   (full[gi]),
        .ovf    (ovf[gi]),
        .spur   (spur[gi]),
        .starve (starve[gi])
      );
    end
  endgenerate

  assign io_oeb = '0;

endmodule

// File: tb/tb_pes_req_stager.sv
// Self-checking bench for pes_req_stager: table vectors plus hand sequences,
// all results flow through an expectation queue checked one cycle later.
module tb_pes_req_stager;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int MAXC  = 100;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] push, grant;
  logic [N-1:0] req, full, ovf, spur, starve, io_oeb;

  always #5 clk = ~clk;

  pes_req_stager #(
    .NUM_REQ   (N),
    .DEPTH     (DEPTH),
    .CNT_W     (4),
    .MAX_COUNT (MAXC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .grant  (grant),
    .req    (req),
    .full   (full),
    .ovf    (ovf),
    .spur   (spur),
    .starve (starve),
    .io_oeb (io_oeb)
  );

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] full;
    logic [3:0] ovf;
    logic [3:0] spur;
    logic [3:0] starve;
  } outs_t;

  typedef struct {
    logic [3:0] p;
    logic [3:0] g;
    outs_t      exp;
  } vec_t;

  outs_t exp_q[$];
  vec_t  tbl[16];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;

  // Reference state of the channels
  int       m_cnt[N];
  int       m_wait[N];
  logic [N-1:0] m_ovf, m_spur;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input outs_t e);
    check({tag, ".req"},    req,    e.req);
    check({tag, ".full"},   full,   e.full);
    check({tag, ".ovf"},    ovf,    e.ovf);
    check({tag, ".spur"},   spur,   e.spur);
    check({tag, ".starve"}, starve, e.starve);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i]  = 0;
      m_wait[i] = 0;
    end
    m_ovf  = '0;
    m_spur = '0;
  endtask

  task automatic model_step(input logic [3:0] p, input logic [3:0] g, output outs_t o);
    bit pop;
    for (int i = 0; i < N; i++) begin
      pop = g[i] && (m_cnt[i] != 0);
      if (g[i] && m_cnt[i] == 0) m_spur[i] = 1'b1;
      if (pop || m_cnt[i] == 0) m_wait[i] = 0;
      else if (m_wait[i] < MAXC) m_wait[i]++;
      if (p[i] && !pop) begin
        if (m_cnt[i] == DEPTH) m_ovf[i] = 1'b1;
        else m_cnt[i]++;
      end else if (pop && !p[i]) begin
        m_cnt[i]--;
      end
    end
    for (int i = 0; i < N; i++) begin
      o.req[i]    = (m_cnt[i] != 0);
      o.full[i]   = (m_cnt[i] == DEPTH);
      o.starve[i] = (m_wait[i] >= MAXC);
    end
    o.ovf  = m_ovf;
    o.spur = m_spur;
  endtask

  // Called at a falling edge: drive, let one rising edge pass, compare at the next falling edge.
  task automatic do_cycle(input logic [3:0] p, input logic [3:0] g,
                          input bit use_tbl, input outs_t texp);
    outs_t mo, e;
    model_step(p, g, mo);
    push  = p;
    grant = g;
    exp_q.push_back(use_tbl ? texp : mo);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    e = exp_q.pop_front();
    $display("cyc %0d push=%b grant=%b req=%b full=%b ovf=%b spur=%b starve=%b",
             cyc, p, g, req, full, ovf, spur, starve);
    check_outs("seq", e);
  endtask

  function automatic vec_t mk(input logic [3:0] p, input logic [3:0] g, input logic [3:0] r,
                              input logic [3:0] f, input logic [3:0] o, input logic [3:0] s);
    vec_t v;
    v.p          = p;
    v.g          = g;
    v.exp.req    = r;
    v.exp.full   = f;
    v.exp.ovf    = o;
    v.exp.spur   = s;
    v.exp.starve = 4'b0000;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    outs_t zero_o;
    zero_o = '0;

    tbl[0]  = mk(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    tbl[1]  = mk(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    tbl[2]  = mk(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    tbl[3]  = mk(4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    tbl[4]  = mk(4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
    tbl[5]  = mk(4'b0100, 4'b0001, 4'b0101, 4'b0000, 4'b0001, 4'b0000);
    tbl[6]  = mk(4'b0100, 4'b0000, 4'b0101, 4'b0000, 4'b0001, 4'b0000);
    tbl[7]  = mk(4'b0100, 4'b0000, 4'b0101, 4'b0000, 4'b0001, 4'b0000);
    tbl[8]  = mk(4'b0100, 4'b0000, 4'b0101, 4'b0100, 4'b0001, 4'b0000);
    tbl[9]  = mk(4'b0100, 4'b0100, 4'b0101, 4'b0100, 4'b0001, 4'b0000);
    tbl[10] = mk(4'b0000, 4'b1000, 4'b0101, 4'b0100, 4'b0001, 4'b1000);
    tbl[11] = mk(4'b1000, 4'b1000, 4'b1101, 4'b0100, 4'b0001, 4'b1000);
    tbl[12] = mk(4'b0000, 4'b0001, 4'b1101, 4'b0100, 4'b0001, 4'b1000);
    tbl[13] = mk(4'b0000, 4'b0001, 4'b1101, 4'b0100, 4'b0001, 4'b1000);
    tbl[14] = mk(4'b0000, 4'b0001, 4'b1100, 4'b0100, 4'b0001, 4'b1000);
    tbl[15] = mk(4'b0000, 4'b0001, 4'b1100, 4'b0100, 4'b0001, 4'b1001);

    // Power-on reset
    rst   = 1'b1;
    push  = '0;
    grant = '0;
    model_reset();
    @(negedge clk);
    check_outs("por", zero_o);
    check("io_oeb", io_oeb, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // Table: fill/overflow ch0, push+grant on full ch2, spurious grants on ch3/ch0
    for (int k = 0; k < 16; k++) begin
      do_cycle(tbl[k].p, tbl[k].g, 1'b1, tbl[k].exp);
    end

    // Build counts {3,1,0,4} then assert reset between clock edges
    do_cycle(4'b1011, 4'b0100, 1'b0, zero_o);
    do_cycle(4'b1001, 4'b0100, 1'b0, zero_o);
    do_cycle(4'b1001, 4'b0100, 1'b0, zero_o);
    do_cycle(4'b0000, 4'b0100, 1'b0, zero_o);
    check("pre_rst.req", req, 4'b1011);
    check("pre_rst.full", full, 4'b1000);
    #1 rst = 1'b1;
    #1 check_outs("async_rst", zero_o);
    @(negedge clk);
    check_outs("rst_held", zero_o);
    rst   = 1'b0;
    push  = '0;
    grant = '0;
    model_reset();
    do_cycle(4'b0000, 4'b0000, 1'b0, zero_o);
    check("post_rst.req", req, 4'b0000);

    // Starvation on ch1: asserts once the channel has waited MAXC cycles
    do_cycle(4'b0010, 4'b0000, 1'b0, zero_o);
    for (int k = 1; k <= MAXC + 5; k++) begin
      do_cycle(4'b0000, 4'b0000, 1'b0, zero_o);
      check("starve_thr", starve, (k >= MAXC) ? 4'b0010 : 4'b0000);
    end
    do_cycle(4'b0000, 4'b0010, 1'b0, zero_o);
    check("starve_clr", starve, 4'b0000);
    check("starve_clr.req", req, 4'b0000);
    check("starve_clr.spur", spur, 4'b0000);

    // Multi-bit grant
    do_cycle(4'b1111, 4'b0000, 1'b0, zero_o);
    do_cycle(4'b1111, 4'b0000, 1'b0, zero_o);
    do_cycle(4'b0000, 4'b1111, 1'b0, zero_o);
    check("multi1.req", req, 4'b1111);
    do_cycle(4'b0000, 4'b1111, 1'b0, zero_o);
    check("multi2.req", req, 4'b0000);
    check("multi2.spur", spur, 4'b0000);

    // Random traffic against the reference model
    for (int k = 0; k < 300; k++) begin
      logic [3:0] rp, rg;
      rp = 4'($urandom);
      rg = 4'($urandom) & 4'($urandom);
      do_cycle(rp, rg, 1'b0, zero_o);
    end
    check("io_oeb_end", io_oeb, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pes_req_stager.md
Name: pes_req_stager

Overview:
- Upstream stage of the round-robin arbiter.
- Each of NUM_REQ requestors posts single-cycle push pulses. Each channel keeps a saturating pending-request count and drives the arbiter's req line while that count is non-zero. Each granted bit retires one pending request.
- Also flags overflow, spurious grants and starvation (a channel held requesting too long without a grant) for debug and monitoring.

Parameters:
- NUM_REQ, 4, number of requestor channels; must equal the arbiter width.
- DEPTH, 4, maximum pending requests per channel (2..15).
- CNT_W, 4, width of each pending counter; must satisfy 2^CNT_W > DEPTH.
- MAX_COUNT, 100, starvation threshold in cycles (1..65535).

Ports:
- vccd1  inout  1  power, present only under USE_POWER_PINS
- vssd1  inout  1  ground, present only under USE_POWER_PINS
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- push  input  NUM_REQ  one pulse per cycle per channel; each asserted bit = one new request
- grant  input  NUM_REQ  grant vector from the arbiter; may have more than one bit set
- req  output  NUM_REQ  to arbiter; bit i = (pend_cnt[i] != 0)
- full  output  NUM_REQ  bit i = (pend_cnt[i] == DEPTH)
- ovf  output  NUM_REQ  sticky; push dropped on a full channel
- spur  output  NUM_REQ  sticky; grant seen on a channel with pend_cnt == 0
- starve  output  NUM_REQ  bit i high while wait_cnt[i] >= MAX_COUNT
- io_oeb  output  NUM_REQ  tied to all zeros

Behaviour:
- Reset (async, immediate): every pend_cnt = 0, wait_cnt = 0, ovf = 0, spur = 0. Therefore req = 0, full = 0 and starve = 0 while rst is high and after release.
- req, full and starve are decoded combinationally from registers only. There is no combinational path from push or grant to any output.
- Latency: a push at edge n makes req visible after edge n. A grant at edge n decrements the count at edge n.
- Per-channel update, with pop = grant[i] & (pend_cnt != 0):
  - push without pop: if not full, count +1; if full, count unchanged and ovf[i] set.
  - pop without push: count -1.
  - push and pop together: count unchanged, even when full. No ovf in this case.
  - grant[i] with count 0: spur[i] set, count stays 0. If push[i] is also high, the push is accepted and the count becomes 1.
  - The count never wraps below 0 or above DEPTH.
- Wait timer, per channel:
  - Clears on pop, or when the count is 0.
  - Otherwise increments each cycle that the count is non-zero.
  - Saturates at MAX_COUNT, so starve holds high until the next pop.
- Channels are fully independent. Simultaneous events on different channels do not interact.
- ovf and spur clear only on rst.
- Width rules:
  - Counters are unsigned.
  - wait_cnt is 16 bits wide.
  - All comparisons are zero-extended to counter width.

Decomposition:
- Shared include pes_arb_defs.vh holds:
  - NUM_REQ default
  - default MAX_COUNT
  - default DEPTH/CNT_W
  - the COCOTB_SIM dump hook convention for this block (pes_req_stager.vcd)
- One natural sub-module, pes_req_chan, covering a single channel:
  - pending counter
  - wait timer
  - ovf/spur flags
- The top instantiates pes_req_chan NUM_REQ times with a generate loop and ties io_oeb to all zeros.

Test Plan:
- Reset check: assert rst mid-run with counts {3,1,0,4} -> all outputs 0 immediately, before the next clk edge. After release, req = 0000.
- Fill and overflow: 5 push pulses on ch0 with grant = 0 (DEPTH 4) -> pend_cnt0 = 4, full = 0001, ovf = 0001. Then 4 grant pulses on ch0 -> req0 drops after the 4th edge.
- Simultaneous push and grant on full ch2 -> count stays 4, ovf2 stays 0, full stays 0100.
- Spurious grant: grant = 1000 with ch3 empty -> spur = 1000, count3 = 0. Grant = 1000 with push = 1000 on an empty ch3 -> count3 = 1, spur3 set.
- Starvation: push ch1 once, hold grant = 0 for 100 cycles -> starve = 0010 from cycle 100 onward. One grant on ch1 -> starve1 = 0 and wait_cnt1 = 0 on the next cycle.
- Multi-bit grant: counts {2,2,2,2}, grant = 1111 for one cycle -> counts {1,1,1,1}, req = 1111. A second grant = 1111 -> req = 0000.
